// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced button edge pulses as short, long or double presses
// Optional event counter output enabled by defining PRESS_CLASSIFIER_STATS_EN.
module press_classifier #(
    parameter int unsigned LONG_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES  = 250,
    parameter int unsigned TMR_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rising_edge_i,
    input  logic       falling_edge_i,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       double_press_o,
    output logic       busy_o
`ifdef PRESS_CLASSIFIER_STATS_EN
    ,
    output logic [7:0] event_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_GAP,
        SECOND,
        LONG_HELD
    } state_t;

    // Threshold compares happen one count early so the pulse lands on edge N+THRESHOLD.
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] tmr;
    logic             rise;
    logic             fall;
    logic             short_next;
    logic             long_next;
    logic             double_next;

    // Simultaneous rise and fall carry no usable information and are dropped.
    assign rise = rising_edge_i & ~falling_edge_i;
    assign fall = falling_edge_i & ~rising_edge_i;

    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_next = PRESSED;
            end
            PRESSED: begin
                if (tmr == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = fall ? IDLE : LONG_HELD;
                end else if (fall) begin
                    state_next = WAIT_GAP;
                end
            end
            LONG_HELD: begin
                if (fall) state_next = IDLE;
            end
            WAIT_GAP: begin
                // A rise on the timeout edge starts a fresh press rather than being lost.
                if (tmr == GAP_LAST) begin
                    short_next = 1'b1;
                    state_next = rise ? PRESSED : IDLE;
                end else if (rise) begin
                    state_next = SECOND;
                end
            end
            SECOND: begin
                if (fall || tmr == LONG_LAST) begin
                    double_next = 1'b1;
                    state_next  = fall ? IDLE : LONG_HELD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tmr            <= '0;
            short_press_o  <= 1'b0;
            long_press_o   <= 1'b0;
            double_press_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_next;
            tmr            <= (state_next != state) ? '0 : tmr + 1'b1;
            short_press_o  <= short_next;
            long_press_o   <= long_next;
            double_press_o <= double_next;
            busy_o         <= (state_next != IDLE);
        end
    end

`ifdef PRESS_CLASSIFIER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_cnt_o <= 8'd0;
        end else if (short_next || long_next || double_next) begin
            event_cnt_o <= event_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - directed table-driven bench for press_classifier (LONG_CYCLES=8, GAP_CYCLES=4)
module tb_press_classifier;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rising_edge_i = 1'b0;
    logic       falling_edge_i = 1'b0;
    logic       short_press_o;
    logic       long_press_o;
    logic       double_press_o;
    logic       busy_o;
`ifdef PRESS_CLASSIFIER_STATS_EN
    logic [7:0] event_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    press_classifier #(
        .LONG_CYCLES(8),
        .GAP_CYCLES (4),
        .TMR_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rising_edge_i (rising_edge_i),
        .falling_edge_i(falling_edge_i),
        .short_press_o (short_press_o),
        .long_press_o  (long_press_o),
        .double_press_o(double_press_o),
        .busy_o        (busy_o)
`ifdef PRESS_CLASSIFIER_STATS_EN
        ,
        .event_cnt_o   (event_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Event kinds: 0 none, 1 short, 2 long, 3 double. Edge fields of -1 are unused.
    typedef struct {
        string name;
        int    r0, r1, f0, f1;
        int    k0, e0, k1, e1;
        int    idle;
        int    rst;
    } scen_t;

    scen_t tbl[10];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rising_edge_i = 1'b0;
        falling_edge_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic bit pulse_at(input scen_t s, input int kind, input int e);
        return (s.k0 == kind && s.e0 == e) || (s.k1 == kind && s.e1 == e);
    endfunction

    initial begin
        tbl[0] = '{"short",       10, -1, 13, -1, 1, 17, 0, -1, 17, -1};
        tbl[1] = '{"long",        10, -1, 30, -1, 2, 18, 0, -1, 30, -1};
        tbl[2] = '{"double",      10, 14, 12, 16, 3, 16, 0, -1, 16, -1};
        tbl[3] = '{"gap_edge",    10, 16, 12, 18, 1, 16, 1, 22, 22, -1};
        tbl[4] = '{"reset_gap",   10, -1, 12, -1, 0, -1, 0, -1, 14, 14};
        tbl[5] = '{"illegal",     10, -1,  5, 10, 0, -1, 0, -1,  0, -1};
        tbl[6] = '{"long_fall_n", 10, -1, 18, -1, 2, 18, 0, -1, 18, -1};
        tbl[7] = '{"second_long", 10, 14, 12, 28, 3, 22, 0, -1, 28, -1};
        tbl[8] = '{"both_press",  10, 12, 12, 14, 1, 18, 0, -1, 18, -1};
        tbl[9] = '{"late_rise",   10, 15, 12, 17, 3, 17, 0, -1, 17, -1};

        // Outputs while held in reset, then just after release.
        #1;
        check("rst_short", short_press_o, 0);
        check("rst_long", long_press_o, 0);
        check("rst_double", double_press_o, 0);
        check("rst_busy", busy_o, 0);
`ifdef PRESS_CLASSIFIER_STATS_EN
        check("rst_cnt", event_cnt_o, 0);
`endif
        do_reset();
        @(posedge clk);
        #1;
        check("post_rst_busy", busy_o, 0);
        check("post_rst_short", short_press_o, 0);

        for (int t = 0; t < 10; t++) begin
            int first_rise;
            int exp_cnt;
            do_reset();
            first_rise = (tbl[t].r0 < 0) ? 1000 : tbl[t].r0;
            exp_cnt = 0;
            for (int e = 1; e <= 32; e++) begin
                bit in_rst;
                @(negedge clk);
                rising_edge_i  = (tbl[t].r0 == e) || (tbl[t].r1 == e);
                falling_edge_i = (tbl[t].f0 == e) || (tbl[t].f1 == e);
                if (tbl[t].rst == e) reset = 1'b1;
                if (tbl[t].rst >= 0 && tbl[t].rst + 1 == e) reset = 1'b0;
                @(posedge clk);
                #1;
                in_rst = (tbl[t].rst >= 0 && e >= tbl[t].rst);
                if (pulse_at(tbl[t], 1, e) || pulse_at(tbl[t], 2, e) || pulse_at(tbl[t], 3, e))
                    exp_cnt++;
                check($sformatf("%s_e%0d_short", tbl[t].name, e), short_press_o,
                      (!in_rst && pulse_at(tbl[t], 1, e)) ? 1 : 0);
                check($sformatf("%s_e%0d_long", tbl[t].name, e), long_press_o,
                      (!in_rst && pulse_at(tbl[t], 2, e)) ? 1 : 0);
                check($sformatf("%s_e%0d_double", tbl[t].name, e), double_press_o,
                      (!in_rst && pulse_at(tbl[t], 3, e)) ? 1 : 0);
                check($sformatf("%s_e%0d_busy", tbl[t].name, e), busy_o,
                      (e >= first_rise && e < tbl[t].idle) ? 1 : 0);
`ifdef PRESS_CLASSIFIER_STATS_EN
                check($sformatf("%s_e%0d_cnt", tbl[t].name, e), event_cnt_o,
                      in_rst ? 0 : exp_cnt);
`endif
            end
            rising_edge_i  = 1'b0;
            falling_edge_i = 1'b0;
        end

        // Back-to-back short presses: each pulse seen once, counter wraps after 256.
        begin
            int shorts;
            do_reset();
            shorts = 0;
            for (int p = 0; p < 256; p++) begin
                @(negedge clk);
                rising_edge_i = 1'b1;
                @(negedge clk);
                rising_edge_i = 1'b0;
                falling_edge_i = 1'b1;
                @(negedge clk);
                falling_edge_i = 1'b0;
                for (int w = 0; w < 5; w++) begin
                    @(posedge clk);
                    #1;
                    if (short_press_o) shorts++;
                end
`ifdef PRESS_CLASSIFIER_STATS_EN
                if (p == 0) check("cnt_first_press", event_cnt_o, 1);
`endif
            end
            check("burst_short_count", shorts, 256);
            check("burst_busy_end", busy_o, 0);
`ifdef PRESS_CLASSIFIER_STATS_EN
            check("cnt_wrap", event_cnt_o, 0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
